// File: rtl/distro_ram_port_arb_pkg.sv
// distro_ram_pkg: shared types and helpers for the DistroRAM port arbiter
package distro_ram_pkg;
   typedef enum logic [1:0] {RST, INIT, RUN} state_t;
   typedef enum logic {GNT_WR, GNT_RD} grant_t;
   function automatic int depth_of(input int log_dep);
      return 1 << log_dep;
   endfunction
endpackage

// File: rtl/distro_ram_port_arb_if.sv
// distro_ram_port_arb_if: request, response and RAM-port signals of the arbiter
interface distro_ram_port_arb_if #(parameter int WIDTH = 8, parameter int LOG_DEP = 3);
   logic               wr_valid;
   logic               wr_ready;
   logic [LOG_DEP-1:0] wr_addr;
   logic [WIDTH-1:0]   wr_data;
   logic               rd_valid;
   logic               rd_ready;
   logic [LOG_DEP-1:0] rd_addr;
   logic               resp_valid;
   logic               resp_ready;
   logic [WIDTH-1:0]   resp_data;
   logic               init_done;
   logic               ram_wen;
   logic [LOG_DEP-1:0] ram_addr;
   logic [WIDTH-1:0]   ram_din;
   logic [WIDTH-1:0]   ram_dout;
   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, ram_dout,
      output wr_ready, rd_ready, resp_valid, resp_data, init_done, ram_wen, ram_addr, ram_din
   );
   modport master (
      output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, resp_ready, ram_dout,
      input  wr_ready, rd_ready, resp_valid, resp_data, init_done, ram_wen, ram_addr, ram_din
   );
endinterface

// File: rtl/distro_ram_port_arb_rr_arb2.sv
// rr_arb2: two-way round-robin pick between a write and a read request
module rr_arb2 (
   input  logic clk,
   input  logic rst,
   input  logic req_wr,
   input  logic req_rd,
   output logic gnt_wr,
   output logic gnt_rd
);
   import distro_ram_pkg::*;
   grant_t last;
   // on contention the side that did not win last time goes first
   always_comb begin
      gnt_wr = req_wr & (~req_rd | (last == GNT_RD));
      gnt_rd = req_rd & ~gnt_wr;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) last <= GNT_RD;
      else if (gnt_wr) last <= GNT_WR;
      else if (gnt_rd) last <= GNT_RD;
   end
endmodule

// File: rtl/distro_ram_port_arb.sv
// distro_ram_port_arb: zero-fills DistroRAM after reset, then shares its single
// port between a write channel and a read channel with a registered response
module distro_ram_port_arb #(parameter int WIDTH = 8, parameter int LOG_DEP = 3) (
   input logic                  clk,
   input logic                  rst,
   distro_ram_port_arb_if.slave b
);
   import distro_ram_pkg::*;
   localparam logic [LOG_DEP-1:0] LAST = LOG_DEP'(depth_of(LOG_DEP) - 1);
   state_t             state, state_n;
   logic [LOG_DEP-1:0] init_cnt;
   logic [WIDTH-1:0]   resp_data;
   logic               resp_valid, run, init, gnt_wr, gnt_rd;
   assign run  = state == RUN;
   assign init = state == INIT;
   // a read may only win when the response slot is free or being drained
   rr_arb2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_wr (run & b.wr_valid),
      .req_rd (run & b.rd_valid & (~resp_valid | b.resp_ready)),
      .gnt_wr (gnt_wr),
      .gnt_rd (gnt_rd)
   );
   always_comb begin
      state_n = state;
      state_n = (state == RST) ? INIT : (init && init_cnt == LAST) ? RUN : state;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= RST;
         init_cnt   <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
      end else begin
         state    <= state_n;
         init_cnt <= init ? init_cnt + 1'b1 : init_cnt;
         if (gnt_rd) begin
            resp_valid <= 1'b1;
            resp_data  <= b.ram_dout;
         end else if (resp_valid && b.resp_ready) begin
            resp_valid <= 1'b0;
         end
      end
   end
   assign b.wr_ready   = gnt_wr;
   assign b.rd_ready   = gnt_rd;
   assign b.resp_valid = resp_valid;
   assign b.resp_data  = resp_data;
   assign b.init_done  = run;
   assign b.ram_wen    = init | gnt_wr;
   assign b.ram_addr   = init ? init_cnt : gnt_wr ? b.wr_addr : gnt_rd ? b.rd_addr : '0;
   assign b.ram_din    = gnt_wr ? b.wr_data : '0;
endmodule

// File: tb/tb_distro_ram_port_arb.sv
// tb_distro_ram_port_arb: directed vectors against the arbiter plus a DistroRAM model
module tb_distro_ram_port_arb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int failures = 0;
   localparam logic [2:0] WA [8] = '{3'd0, 3'd2, 3'd5, 3'd1, 3'd4, 3'd3, 3'd7, 3'd6};
   localparam logic [7:0] WD [8] = '{8'hCA, 8'hBE, 8'hDF, 8'hEA, 8'h99, 8'h80, 8'h35, 8'h22};
   localparam logic [7:0] RX [8] = '{8'hCA, 8'hEA, 8'hBE, 8'h80, 8'h99, 8'hDF, 8'h22, 8'h35};
   logic [7:0] mem [8];
   distro_ram_port_arb_if #(.WIDTH(8), .LOG_DEP(3)) b ();
   distro_ram_port_arb #(.WIDTH(8), .LOG_DEP(3)) dut (.clk(clk), .rst(rst), .b(b.slave));
   always #5 clk = ~clk;
   always @(posedge clk) if (b.ram_wen) mem[b.ram_addr] <= b.ram_din;
   assign b.ram_dout = mem[b.ram_addr];
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic init_seq();
      @(negedge clk);
      rst = 1'b0;
      step();
      for (int i = 0; i < 8; i++) begin
         b.wr_valid = 1'b1;
         b.rd_valid = 1'b1;
         #1;
         chk("init_wen", b.ram_wen, 1);
         chk("init_addr", b.ram_addr, i);
         chk("init_din", b.ram_din, 0);
         chk("init_rdy", {b.wr_ready, b.rd_ready}, 0);
         chk("init_done_lo", b.init_done, 0);
         b.wr_valid = 1'b0;
         b.rd_valid = 1'b0;
         step();
      end
      chk("init_done_hi", b.init_done, 1);
      chk("init_wen_off", b.ram_wen, 0);
   endtask
   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      b.wr_valid = 1'b1;
      b.wr_addr = a;
      b.wr_data = d;
      #1;
      chk("wr_ready", b.wr_ready, 1);
      chk("wr_din", b.ram_din, d);
      step();
      b.wr_valid = 1'b0;
   endtask
   task automatic rd(input logic [2:0] a, input logic [7:0] e);
      b.rd_valid = 1'b1;
      b.rd_addr = a;
      #1;
      chk("rd_ready", b.rd_ready, 1);
      step();
      b.rd_valid = 1'b0;
      chk("rd_resp_valid", b.resp_valid, 1);
      chk("rd_resp_data", b.resp_data, e);
   endtask
   initial begin
      b.wr_valid = 1'b1;
      b.wr_addr = 3'd5;
      b.wr_data = 8'h77;
      b.rd_valid = 1'b1;
      b.rd_addr = 3'd0;
      b.resp_ready = 1'b1;
      #3;
      chk("rst_rdy", {b.wr_ready, b.rd_ready}, 0);
      chk("rst_resp", {b.resp_valid, b.resp_data}, 0);
      chk("rst_init_done", b.init_done, 0);
      chk("rst_ram", {b.ram_wen, b.ram_addr, b.ram_din}, 0);
      b.wr_valid = 1'b0;
      b.rd_valid = 1'b0;
      init_seq();
      rd(3'd5, 8'h00);
      for (int i = 0; i < 8; i++) wr(WA[i], WD[i]);
      b.rd_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         b.rd_addr = 3'(i);
         #1;
         chk("seq_rd_ready", b.rd_ready, 1);
         step();
         chk("seq_resp_valid", b.resp_valid, 1);
         chk("seq_resp_data", b.resp_data, RX[i]);
      end
      b.rd_valid = 1'b0;
      step();
      b.wr_valid = 1'b1;
      b.wr_addr = 3'd7;
      b.wr_data = 8'h35;
      b.rd_valid = 1'b1;
      b.rd_addr = 3'd7;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("contend", {b.wr_ready, b.rd_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
         step();
      end
      b.wr_valid = 1'b0;
      b.rd_valid = 1'b0;
      step();
      wr(3'd3, 8'h5A);
      rd(3'd3, 8'h5A);
      step();
      b.resp_ready = 1'b0;
      rd(3'd0, 8'hCA);
      b.rd_valid = 1'b1;
      b.rd_addr = 3'd1;
      b.wr_valid = 1'b1;
      b.wr_addr = 3'd6;
      b.wr_data = 8'h22;
      #1;
      chk("bp_rd_blocked", b.rd_ready, 0);
      chk("bp_wr_granted", b.wr_ready, 1);
      step();
      b.wr_valid = 1'b0;
      chk("bp_hold_valid", b.resp_valid, 1);
      chk("bp_hold_data", b.resp_data, 8'hCA);
      chk("bp_rd_still_blocked", b.rd_ready, 0);
      b.resp_ready = 1'b1;
      #1;
      chk("bp_pop_rd_ready", b.rd_ready, 1);
      step();
      b.rd_valid = 1'b0;
      chk("bp_b2b_valid", b.resp_valid, 1);
      chk("bp_b2b_data", b.resp_data, 8'hEA);
      step();
      chk("bp_drained", b.resp_valid, 0);
      b.resp_ready = 1'b0;
      rd(3'd2, 8'hBE);
      wr(3'd4, 8'h11);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_resp", b.resp_valid, 0);
      chk("mid_rst_init_done", b.init_done, 0);
      chk("mid_rst_wen", b.ram_wen, 0);
      b.resp_ready = 1'b1;
      init_seq();
      b.wr_valid = 1'b1;
      b.wr_addr = 3'd0;
      b.wr_data = 8'h00;
      b.rd_valid = 1'b1;
      b.rd_addr = 3'd4;
      #1;
      chk("post_rst_first_wr", {b.wr_ready, b.rd_ready}, 2'b10);
      step();
      chk("post_rst_then_rd", {b.wr_ready, b.rd_ready}, 2'b01);
      step();
      b.wr_valid = 1'b0;
      b.rd_valid = 1'b0;
      chk("refill_resp_data4", b.resp_data, 8'h00);
      rd(3'd2, 8'h00);
      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
